// File: rtl/tl_pkg.sv
// Shared types and constants for the two-approach intersection controller.
// Exports the state enum (3-bit, fixed encoding), the lamp patterns
// {red,yellow,green} and a helper mapping a steady state to its lamp pair.
package tl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LIGHT_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        A_GREEN  = 3'd1,
        A_YELLOW = 3'd2,
        ALLRED_A = 3'd3,
        B_GREEN  = 3'd4,
        B_YELLOW = 3'd5,
        ALLRED_B = 3'd6,
        FLASH    = 3'd7
    } tl_state_e;

    localparam logic [LIGHT_W-1:0] RED = 3'b100;
    localparam logic [LIGHT_W-1:0] YEL = 3'b010;
    localparam logic [LIGHT_W-1:0] GRN = 3'b001;
    localparam logic [LIGHT_W-1:0] OFF = 3'b000;

    // Lamp pair {light_a, light_b} for a state; anything unlisted shows all red.
    function automatic logic [2*LIGHT_W-1:0] lights_of(input tl_state_e s);
        case (s)
            A_GREEN:  return {GRN, RED};
            A_YELLOW: return {YEL, RED};
            B_GREEN:  return {RED, GRN};
            B_YELLOW: return {RED, YEL};
            default:  return {RED, RED};
        endcase
    endfunction

endpackage

// File: rtl/tl_intersection_ctrl_if.sv
// Signal bundle between the controller and its environment.
//   en       run enable (low freezes all timing)
//   sense_b  side-road vehicle demand
//   ped_req  pedestrian button
//   flash    night-flash request
//   light_a  approach A lamps {r,y,g}
//   light_b  approach B lamps {r,y,g}
//   walk     pedestrian walk lamp
//   state_o  current state encoding
//   tick_o   one-clock pulse per timing tick
// master: environment side (drives requests); slave: controller side.
interface tl_intersection_ctrl_if;

    logic       en;
    logic       sense_b;
    logic       ped_req;
    logic       flash;
    logic [2:0] light_a;
    logic [2:0] light_b;
    logic       walk;
    logic [2:0] state_o;
    logic       tick_o;

    modport master (
        output en, sense_b, ped_req, flash,
        input  light_a, light_b, walk, state_o, tick_o
    );

    modport slave (
        input  en, sense_b, ped_req, flash,
        output light_a, light_b, walk, state_o, tick_o
    );

endinterface

// File: rtl/tl_intersection_ctrl_tick_gen.sv
// Timing-tick prescaler: counts 0..TICK_DIV-1 while en is high and pulses
// tick_c for the clock in which it wraps. Holds its count while en is low.
//   clk, rst  clock and asynchronous active-high reset
//   en        count enable
//   tick_c    one-clock tick pulse (decoded, qualified by en)
module tl_tick_gen #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] presc;

    assign tick_c = en && (presc == PW'(TICK_DIV - 1));

    // Prescaler counter, wraps on the tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick_c ? '0 : presc + PW'(1);
        end
    end

endmodule

// File: rtl/tl_intersection_ctrl.sv
// Two-approach traffic-light controller (main road A, side road B, pedestrian
// walk on A). All timing runs off a clock-enable tick; B is served only on
// demand, pedestrian requests are latched until the next A green.
//   clk, rst  system clock, asynchronous active-high reset
//   bus       tl_intersection_ctrl_if.slave (requests in, lamps/debug out)
// Optional night-flash mode is built when FLASH_MODE_EN is defined; otherwise
// the flash input is ignored and the FLASH encoding is treated as illegal.
module tl_intersection_ctrl #(
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned T_GREEN_A = 30,
    parameter int unsigned T_GREEN_B = 20,
    parameter int unsigned T_YELLOW  = 3,
    parameter int unsigned T_ALLRED  = 2,
    parameter int unsigned T_WALK    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    tl_intersection_ctrl_if.slave bus
);

    import tl_pkg::*;

    localparam logic [CNT_W-1:0] LAST_GA = CNT_W'(T_GREEN_A - 1);
    localparam logic [CNT_W-1:0] LAST_GB = CNT_W'(T_GREEN_B - 1);
    localparam logic [CNT_W-1:0] LAST_Y  = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LAST_AR = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] WALK_N  = CNT_W'(T_WALK);

    logic              tick;
    tl_state_e         state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              ped_pend, ped_n;
    logic              walk_arm, arm_n;
    logic [2:0]        la_q, lb_q, la_n, lb_n;
    logic              walk_q, walk_n;
`ifdef FLASH_MODE_EN
    logic              blink, blink_n;
`else
    logic              unused_flash;
    assign unused_flash = bus.flash;
`endif

    tl_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (bus.en),
        .tick_c (tick)
    );

    // Next state, phase counter, pedestrian latch and the lamp values that
    // the next state will show (lamps are registered alongside the state).
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ped_n   = ped_pend | bus.ped_req;
        arm_n   = walk_arm;
`ifdef FLASH_MODE_EN
        blink_n = blink;
`endif
        if (tick) begin
            cnt_n = (cnt == '1) ? cnt : cnt + CNT_W'(1);
            case (state)
                IDLE:     state_n = ALLRED_B;
                // A green is a minimum: it ends on the first tick at or past
                // its length that sees demand from B or a pedestrian.
                A_GREEN:  if (cnt >= LAST_GA && (bus.sense_b || ped_pend)) state_n = A_YELLOW;
                A_YELLOW: if (cnt == LAST_Y)  state_n = ALLRED_A;
                ALLRED_A: if (cnt == LAST_AR) state_n = B_GREEN;
                B_GREEN:  if (cnt == LAST_GB) state_n = B_YELLOW;
                B_YELLOW: if (cnt == LAST_Y)  state_n = ALLRED_B;
                ALLRED_B: if (cnt == LAST_AR) state_n = A_GREEN;
                default:  state_n = ALLRED_B;
            endcase
`ifdef FLASH_MODE_EN
            // Flash request overrides the normal sequence on any tick.
            if (state == FLASH) begin
                blink_n = ~blink;
                state_n = bus.flash ? FLASH : ALLRED_B;
            end else if (bus.flash && state != IDLE) begin
                state_n = FLASH;
                blink_n = 1'b1;
            end
`endif
        end

        if (state_n != state) begin
            cnt_n = '0;
            // Entering A green consumes the pending request; a request in the
            // same cycle survives for the next cycle.
            if (state_n == A_GREEN) begin
                arm_n = ped_pend;
                ped_n = bus.ped_req;
            end
        end

        {la_n, lb_n} = lights_of(state_n);
        walk_n       = (state_n == A_GREEN) && arm_n && (cnt_n < WALK_N);
`ifdef FLASH_MODE_EN
        if (state_n == FLASH) begin
            la_n   = blink_n ? YEL : OFF;
            lb_n   = blink_n ? RED : OFF;
            walk_n = 1'b0;
        end
`endif
    end

    // State, timing and registered outputs; everything holds while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ped_pend <= 1'b0;
            walk_arm <= 1'b0;
            la_q     <= RED;
            lb_q     <= RED;
            walk_q   <= 1'b0;
`ifdef FLASH_MODE_EN
            blink    <= 1'b0;
`endif
        end else if (bus.en) begin
            state    <= state_n;
            cnt      <= cnt_n;
            ped_pend <= ped_n;
            walk_arm <= arm_n;
            la_q     <= la_n;
            lb_q     <= lb_n;
            walk_q   <= walk_n;
`ifdef FLASH_MODE_EN
            blink    <= blink_n;
`endif
        end
    end

    assign bus.light_a = la_q;
    assign bus.light_b = lb_q;
    assign bus.walk    = walk_q;
    assign bus.state_o = state;
    assign bus.tick_o  = tick;

endmodule

// File: tb/tb_tl_intersection_ctrl.sv
// Directed bench for tl_intersection_ctrl with TICK_DIV=4, T_GREEN_A=5,
// T_GREEN_B=3, T_YELLOW=2, T_ALLRED=1, T_WALK=2 (one tick = 4 clk).
module tb_tl_intersection_ctrl;

    import tl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tl_intersection_ctrl_if bus_i ();

    tl_intersection_ctrl #(
        .TICK_DIV  (4),
        .CNT_W     (8),
        .T_GREEN_A (5),
        .T_GREEN_B (3),
        .T_YELLOW  (2),
        .T_ALLRED  (1),
        .T_WALK    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_i)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Yellow/green on both approaches at once is never allowed.
    always @(negedge clk) begin
        if (rst === 1'b0)
            chk("conflict", 32'((bus_i.light_a[1:0] != 2'b00) && (bus_i.light_b[1:0] != 2'b00)), 32'd0);
    end

    // Called at the first negedge of a phase; checks lamps and phase length,
    // returns at the first negedge of the following phase.
    task automatic run_phase(input string tag, input logic [2:0] st, input int len,
                             input logic [2:0] la, input logic [2:0] lb);
        int n;
        chk({tag, "_state"}, 32'(bus_i.state_o), 32'(st));
        chk({tag, "_la"}, 32'(bus_i.light_a), 32'(la));
        chk({tag, "_lb"}, 32'(bus_i.light_b), 32'(lb));
        n = 1;
        while (n <= len + 100) begin
            @(negedge clk);
            if (bus_i.state_o != st) break;
            n++;
        end
        chk({tag, "_len"}, 32'(n), 32'(len));
    endtask

    task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
        int n;
        n = 0;
        while (bus_i.state_o != st && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus_i.state_o), 32'(st));
    endtask

    initial begin
        int tk;
        int n;
        int walk_cnt;
        int bad;

        rst           = 1'b1;
        bus_i.en      = 1'b1;
        bus_i.sense_b = 1'b0;
        bus_i.ped_req = 1'b0;
        bus_i.flash   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_la", 32'(bus_i.light_a), 32'(RED));
        chk("rst_lb", 32'(bus_i.light_b), 32'(RED));
        chk("rst_walk", 32'(bus_i.walk), 32'd0);
        chk("rst_state", 32'(bus_i.state_o), 32'(IDLE));
        chk("rst_tick", 32'(bus_i.tick_o), 32'd0);

        // No demand: settle into A green and stay there.
        rst = 1'b0;
        run_phase("idle0", IDLE, 4, RED, RED);
        run_phase("arb0", ALLRED_B, 4, RED, RED);
        tk = 0;
        repeat (200) begin
            if (bus_i.tick_o) tk++;
            @(negedge clk);
        end
        chk("tick_count", 32'(tk), 32'd50);
        chk("ag_rest_state", 32'(bus_i.state_o), 32'(A_GREEN));
        chk("ag_rest_la", 32'(bus_i.light_a), 32'(GRN));
        chk("ag_rest_lb", 32'(bus_i.light_b), 32'(RED));
        chk("ag_rest_walk", 32'(bus_i.walk), 32'd0);

        // Continuous side-road demand: full cycle.
        bus_i.sense_b = 1'b1;
        wait_state("to_ay1", A_YELLOW, 20);
        run_phase("ay1", A_YELLOW, 8, YEL, RED);
        run_phase("ara1", ALLRED_A, 4, RED, RED);
        run_phase("bg1", B_GREEN, 12, RED, GRN);
        run_phase("by1", B_YELLOW, 8, RED, YEL);
        run_phase("arb1", ALLRED_B, 4, RED, RED);
        run_phase("ag1", A_GREEN, 20, GRN, RED);
        run_phase("ay2", A_YELLOW, 8, YEL, RED);
        run_phase("ara2", ALLRED_A, 4, RED, RED);

        // Pedestrian pulse during B green, demand from B removed.
        bus_i.sense_b = 1'b0;
        bus_i.ped_req = 1'b1;
        @(negedge clk);
        bus_i.ped_req = 1'b0;
        run_phase("bg2", B_GREEN, 11, RED, GRN);
        run_phase("by2", B_YELLOW, 8, RED, YEL);
        run_phase("arb2", ALLRED_B, 4, RED, RED);

        // Walk for the first two ticks; second pulse at cnt=1 ends A green.
        walk_cnt = 0;
        n = 0;
        while (bus_i.state_o == A_GREEN && n < 100) begin
            if (bus_i.walk) walk_cnt++;
            bus_i.ped_req = (n == 4);
            n++;
            @(negedge clk);
        end
        bus_i.ped_req = 1'b0;
        chk("walk_len", 32'(walk_cnt), 32'd8);
        chk("ag_ped_len", 32'(n), 32'd20);
        run_phase("ay3", A_YELLOW, 8, YEL, RED);
        run_phase("ara3", ALLRED_A, 4, RED, RED);
        run_phase("bg3", B_GREEN, 12, RED, GRN);

        // Reset in the middle of B yellow.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mrst_la", 32'(bus_i.light_a), 32'(RED));
        chk("mrst_lb", 32'(bus_i.light_b), 32'(RED));
        chk("mrst_walk", 32'(bus_i.walk), 32'd0);
        chk("mrst_state", 32'(bus_i.state_o), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        run_phase("idle_r", IDLE, 4, RED, RED);
        run_phase("arb_r", ALLRED_B, 4, RED, RED);
        chk("walk_after_rst", 32'(bus_i.walk), 32'd0);

        // Freeze with en=0 partway through A yellow.
        bus_i.sense_b = 1'b1;
        wait_state("to_ay4", A_YELLOW, 40);
        repeat (5) @(negedge clk);
        bus_i.en = 1'b0;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus_i.tick_o || bus_i.state_o != A_YELLOW || bus_i.light_a != YEL ||
                bus_i.light_b != RED)
                bad++;
        end
        chk("freeze", 32'(bad), 32'd0);
        bus_i.en = 1'b1;
        n = 0;
        while (bus_i.state_o == A_YELLOW && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("ay_resume_len", 32'(n), 32'd3);
        chk("ay_resume_next", 32'(bus_i.state_o), 32'(ALLRED_A));

        bus_i.sense_b = 1'b0;
        wait_state("to_ag5", A_GREEN, 60);
        bus_i.flash = 1'b1;
`ifdef FLASH_MODE_EN
        wait_state("to_flash", FLASH, 8);
        chk("fl0_la", 32'(bus_i.light_a), 32'(YEL));
        chk("fl0_lb", 32'(bus_i.light_b), 32'(RED));
        chk("fl0_walk", 32'(bus_i.walk), 32'd0);
        repeat (4) @(negedge clk);
        chk("fl1_la", 32'(bus_i.light_a), 32'(OFF));
        chk("fl1_lb", 32'(bus_i.light_b), 32'(OFF));
        repeat (4) @(negedge clk);
        chk("fl2_la", 32'(bus_i.light_a), 32'(YEL));
        bus_i.flash = 1'b0;
        wait_state("fl_exit", ALLRED_B, 8);
        run_phase("arb_fl", ALLRED_B, 4, RED, RED);
        chk("fl_ag_state", 32'(bus_i.state_o), 32'(A_GREEN));
        chk("fl_ag_la", 32'(bus_i.light_a), 32'(GRN));
`else
        repeat (100) @(negedge clk);
        chk("noflash_state", 32'(bus_i.state_o), 32'(A_GREEN));
        chk("noflash_la", 32'(bus_i.light_a), 32'(GRN));
        bus_i.flash = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
